// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling, one-cycle done/frame-error pulses.
// After a framing error or reset the line must return high before a new start edge is accepted.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rs232_rx_,
    output logic [7:0] rx_data,
    output logic       done_flag,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_data_q;
    logic        sync1_q;
    logic        rx_s_q;
    logic        done_q;
    logic        ferr_q;
    logic        wait_high_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
            // A line caught low mid-frame must not be mistaken for a start bit.
            wait_high_q <= 1'b1;
        end else begin
            sync1_q <= Rs232_rx_;
            rx_s_q  <= sync1_q;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (wait_high_q) begin
                        if (rx_s_q) wait_high_q <= 1'b0;
                    end else if (!rx_s_q) begin
                        state_q <= StStart;
                        cnt_q   <= 16'd0;
                    end
                end
                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q <= 16'd0;
                        idx_q <= 3'd0;
                        state_q <= rx_s_q ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        shift_q[idx_q] <= rx_s_q;
                        cnt_q          <= 16'd0;
                        if (idx_q == 3'd7) state_q <= StStop;
                        else               idx_q   <= idx_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= 16'd0;
                        state_q <= StIdle;
                        if (rx_s_q) begin
                            rx_data_q <= shift_q;
                            done_q    <= 1'b1;
                        end else begin
                            ferr_q      <= 1'b1;
                            wait_high_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign done_flag = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 500, giving clk cycles per serial bit; legal range is even values 4..65534.
REQ-002 Port clk  input  1  is the single system clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-004 Port Rs232_rx_  input  1  is the asynchronous serial line: idle high, 8N1, LSB first.
REQ-005 Port rx_data  output  8  SHALL carry the last correctly framed byte.
REQ-006 Port done_flag  output  1  SHALL be a one-cycle pulse marking a new valid rx_data.
REQ-007 Port frame_err  output  1  SHALL be a one-cycle pulse marking a stop bit sampled low.
REQ-008 Port busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-009 Rs232_rx_ SHALL pass through a 2-flop synchronizer (flops reset to 1); all line decisions SHALL use the synchronized bit rx_s, which lags the pin by 2 cycles.
REQ-010 The FSM SHALL have the states IDLE, START, DATA and STOP, with a bit-cycle counter cnt (16 bits) and a bit index idx (3 bits).
REQ-011 IDLE: when rx_s = 0, the FSM SHALL go to START with cnt = 0; otherwise it SHALL stay in IDLE.
REQ-012 START: cnt SHALL increment each cycle; at cnt = CLKS_PER_BIT/2 - 1 it SHALL sample rx_s.
  - rx_s = 0: go to DATA with cnt = 0 and idx = 0.
  - rx_s = 1: treat as a glitch; return to IDLE with no outputs pulsed.
REQ-013 DATA: at cnt = CLKS_PER_BIT - 1, the FSM SHALL shift rx_s into shift register bit idx (LSB first) and clear cnt.
  - idx = 7: go to STOP.
  - otherwise: increment idx.
REQ-014 STOP: at cnt = CLKS_PER_BIT - 1, the FSM SHALL sample rx_s.
  - rx_s = 1: load rx_data from the shift register and pulse done_flag on the next cycle.
  - rx_s = 0: pulse frame_err on the next cycle and leave rx_data unchanged.
  - In both cases, return to IDLE.
REQ-015 All samples SHALL fall at bit centres; re-arming in IDLE at mid-stop-bit SHALL allow back-to-back frames with no idle gap.
REQ-016 done_flag and frame_err SHALL never assert in the same cycle, and each SHALL be high for exactly 1 cycle per frame.
REQ-017 rx_data SHALL hold its value between frames and SHALL change only in the cycle in which done_flag asserts.
REQ-018 In IDLE, a line held low (break) SHALL produce one frame with frame_err; the FSM SHALL then wait in IDLE for rx_s = 1 before it accepts a new start edge.
REQ-019 Latency from the pin's stop-bit centre to done_flag SHALL be 3 cycles (2 synchronizer + 1 output register).

Reset
REQ-020 While rst = 1, on each clk edge the block SHALL set:
  - state = IDLE; cnt = 0; idx = 0;
  - shift register = 0; synchronizer flops = 1;
  - rx_data = 8'h00; done_flag = 0; frame_err = 0; busy = 0.
REQ-021 rst asserted mid-frame SHALL abort the frame without pulsing any output; after release, reception SHALL restart only on a new falling edge of rx_s.

Verification
REQ-022 Frame 0x29 (start 0, bits 1,0,0,1,0,1,0,0, stop 1), CLKS_PER_BIT = 16 -> rx_data = 8'h29, one done_flag pulse, frame_err stays 0, busy high for the frame.
REQ-023 Frame 0xA5 with stop bit driven 0 -> one frame_err pulse, no done_flag, rx_data keeps its previous value.
REQ-024 Low glitch of 5 cycles on an idle line (CLKS_PER_BIT = 16) -> FSM returns to IDLE, no done_flag or frame_err pulse, rx_data unchanged.
REQ-025 Back-to-back frames 0x29 then 0xD6 with no idle gap -> two done_flag pulses exactly 10*CLKS_PER_BIT cycles apart, rx_data = 8'h29 and then 8'hD6.
REQ-026 rst pulsed for 1 cycle during DATA bit 3 -> all outputs 0 and busy = 0; the following full frame 0x3C -> rx_data = 8'h3C with one done_flag pulse.
REQ-027 Loopback: the existing transmitter's serial output wired to Rs232_rx_ with matching bit timing, bytes 0x00, 0xFF, 0x29 -> each byte received correctly, with exactly one done_flag per byte.
